// File: rtl/cache_pkg.sv
// Shared cache definitions: fill FSM state encoding, block geometry and default timing.
package cache_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

  localparam int unsigned DEF_WORDS_PER_BLOCK = 8;
  localparam int unsigned DEF_MEM_LATENCY     = 4;
  localparam int unsigned BLOCK_BYTES         = 2 * DEF_WORDS_PER_BLOCK;
  localparam int unsigned OFFSET_W            = $clog2(BLOCK_BYTES);

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/dff_r1.sv
// 1-bit register primitive with synchronous active-high reset.
module dff_r1 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_q <= 1'b0;
    else       r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/fill_counter.sv
// Word counter for a block fill: synchronous clear has priority over enable.
module fill_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) r_cnt <= '0;
    else if (i_en)      r_cnt <= r_cnt + CNT_W'(1);
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss controller: requests a whole block from main memory, streams the
// returned words into the data array and writes the tag with the last word.
module cache_fill_fsm
  import cache_pkg::*;
#(
  parameter int unsigned WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
  parameter int unsigned MEM_LATENCY     = DEF_MEM_LATENCY,
  parameter int unsigned ADDR_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              memory_data_valid,
  output logic              fsm_busy,
  output logic              mem_read,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic [ADDR_W-1:0] fill_address,
  output logic              write_tag_array
);

  localparam int unsigned IDX_W     = $clog2(WORDS_PER_BLOCK);
  localparam int unsigned CNT_W     = IDX_W + 1;
  localparam int unsigned BLK_OFF_W = IDX_W + 1;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << BLK_OFF_W) - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(WORDS_PER_BLOCK);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WORDS_PER_BLOCK - 1);

  if (WORDS_PER_BLOCK < 2 || !is_pow2(WORDS_PER_BLOCK)) begin : g_bad_words
    $error("WORDS_PER_BLOCK must be a power of two >= 2");
  end
  if (MEM_LATENCY == 0) begin : g_bad_latency
    $error("MEM_LATENCY must be nonzero");
  end
  if (ADDR_W <= BLK_OFF_W) begin : g_bad_addr
    $error("ADDR_W too narrow for the block offset");
  end
  if (WORDS_PER_BLOCK == DEF_WORDS_PER_BLOCK && BLK_OFF_W != OFFSET_W) begin : g_bad_pkg
    $error("block offset width disagrees with cache_pkg");
  end

  fill_state_t       w_state;
  fill_state_t       w_state_d;
  logic              w_state_q;
  logic [ADDR_W-1:0] r_block_base;
  logic [CNT_W-1:0]  w_req_cnt;
  logic [CNT_W-1:0]  w_rcv_cnt;
  logic              w_cnt_clr;
  logic              w_req_en;
  logic              w_rcv_en;
  logic [ADDR_W-1:0] w_req_off;
  logic [ADDR_W-1:0] w_rcv_off;

  dff_r1 u_state (
    .i_clk (clk),
    .i_rst (rst),
    .i_d   (w_state_d),
    .o_q   (w_state_q)
  );
  assign w_state = fill_state_t'(w_state_q);

  fill_counter #(.CNT_W(CNT_W)) u_req_cnt (
    .i_clk (clk),
    .i_rst (rst),
    .i_clr (w_cnt_clr),
    .i_en  (w_req_en),
    .o_cnt (w_req_cnt)
  );

  fill_counter #(.CNT_W(CNT_W)) u_rcv_cnt (
    .i_clk (clk),
    .i_rst (rst),
    .i_clr (w_cnt_clr),
    .i_en  (w_rcv_en),
    .o_cnt (w_rcv_cnt)
  );

  // Base has its offset bits zeroed, so OR-ing in the word offset can never carry into the tag.
  always_ff @(posedge clk) begin
    if (rst)                                   r_block_base <= '0;
    else if (w_state == IDLE && miss_detected) r_block_base <= miss_address & ~OFF_MASK;
  end

  assign w_req_off = ADDR_W'({w_req_cnt[IDX_W-1:0], 1'b0});
  assign w_rcv_off = ADDR_W'({w_rcv_cnt[IDX_W-1:0], 1'b0});

  always_comb begin
    w_state_d        = w_state;
    w_cnt_clr        = 1'b0;
    w_req_en         = 1'b0;
    w_rcv_en         = 1'b0;
    fsm_busy         = 1'b0;
    mem_read         = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    fill_address     = '0;
    write_tag_array  = 1'b0;
    case (w_state)
      IDLE: begin
        w_cnt_clr = 1'b1;
        if (miss_detected) w_state_d = FILL;
      end
      FILL: begin
        fsm_busy = 1'b1;
        if (w_req_cnt < CNT_FULL) begin
          mem_read       = 1'b1;
          memory_address = r_block_base | w_req_off;
          w_req_en       = 1'b1;
        end
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          fill_address     = r_block_base | w_rcv_off;
          w_rcv_en         = 1'b1;
          if (w_rcv_cnt == CNT_LAST) begin
            write_tag_array = 1'b1;
            w_state_d       = IDLE;
          end
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm with an in-order fixed-latency memory model.
module tb_cache_fill_fsm;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss;
  logic [15:0] miss_addr;
  logic        mem_valid;
  logic        mdl_valid = 1'b0;
  logic        man_valid;
  logic        fsm_busy;
  logic        mem_read;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [15:0] fill_address;
  logic        write_tag_array;
  logic [35:0] obs;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rq[$];
  int push_idx = 0;
  int gap_word = -1;
  int gap_len  = 0;

  always #5 clk = ~clk;

  assign mem_valid = mdl_valid | man_valid;
  assign obs = {fsm_busy, mem_read, memory_address, write_data_array, fill_address, write_tag_array};

  cache_fill_fsm #(
    .WORDS_PER_BLOCK (8),
    .MEM_LATENCY     (4),
    .ADDR_W          (16)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss),
    .miss_address      (miss_addr),
    .memory_data_valid (mem_valid),
    .fsm_busy          (fsm_busy),
    .mem_read          (mem_read),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .fill_address      (fill_address),
    .write_tag_array   (write_tag_array)
  );

  // Memory: each request returns LAT cycles later, in order; one chosen word can be held back.
  always @(posedge clk) begin
    cyc++;
    #1;
    mdl_valid = (rq.size() > 0) && (rq[0] <= cyc);
  end

  always @(negedge clk) begin
    if (mdl_valid) void'(rq.pop_front());
    if (mem_read) begin
      rq.push_back(cyc + LAT + ((push_idx == gap_word) ? gap_len : 0));
      push_idx++;
    end
  end

  // Expected {busy, rd, addr, wr, fill_addr, tag} on cycle c of a fill that missed on cycle 0.
  function automatic logic [35:0] model(input int c, input logic [15:0] base, input int gap);
    logic busy, rd, wr, tag;
    logic [15:0] a, fa;
    int wc;
    rd  = (c >= 1 && c <= 8);
    a   = rd ? base + 16'(2 * (c - 1)) : 16'h0000;
    wr  = 1'b0;
    fa  = 16'h0000;
    tag = 1'b0;
    for (int k = 0; k < 8; k++) begin
      wc = 5 + k + ((k >= 3) ? gap : 0);
      if (c == wc) begin
        wr  = 1'b1;
        fa  = base + 16'(2 * k);
        tag = (k == 7);
      end
    end
    busy = (c >= 1 && c <= 12 + gap);
    return {busy, rd, a, wr, fa, tag};
  endfunction

  task automatic test_reset();
    rst = 1'b1; miss = 1'b1; miss_addr = 16'h1230; man_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (obs !== 36'h0) begin bad++; $display("FAIL reset_outputs got=%h exp=%h", obs, 36'h0); end
    @(posedge clk); #1;
    rst = 1'b0; miss = 1'b0; man_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (obs !== 36'h0) begin bad++; $display("FAIL reset_idle got=%h exp=%h", obs, 36'h0); end
  endtask

  task automatic test_basic();
    logic [35:0] exp;
    push_idx = 0; gap_word = -1; gap_len = 0;
    for (int c = 0; c <= 14; c++) begin
      @(posedge clk); #1;
      miss = (c == 0); miss_addr = 16'h1236;
      @(negedge clk);
      exp = model(c, 16'h1230, 0);
      total++;
      if (obs !== exp) begin bad++; $display("FAIL basic c=%0d got=%h exp=%h", c, obs, exp); end
    end
  endtask

  task automatic test_gapped();
    logic [35:0] exp;
    push_idx = 0; gap_word = 3; gap_len = 3;
    for (int c = 0; c <= 17; c++) begin
      @(posedge clk); #1;
      miss = (c == 0); miss_addr = 16'h567C;
      @(negedge clk);
      exp = model(c, 16'h5670, 3);
      total++;
      if (obs !== exp) begin bad++; $display("FAIL gapped c=%0d got=%h exp=%h", c, obs, exp); end
    end
    gap_word = -1; gap_len = 0;
  endtask

  task automatic test_ignored();
    logic [35:0] exp;
    push_idx = 0;
    for (int c = 0; c <= 16; c++) begin
      @(posedge clk); #1;
      miss      = (c == 0) || (c == 3);
      miss_addr = (c == 3) ? 16'h4000 : 16'h1230;
      @(negedge clk);
      exp = model(c, 16'h1230, 0);
      total++;
      if (obs !== exp) begin bad++; $display("FAIL ignored_miss c=%0d got=%h exp=%h", c, obs, exp); end
    end
    @(posedge clk); #1;
    man_valid = 1'b1;
    @(negedge clk);
    total++;
    if (obs !== 36'h0) begin bad++; $display("FAIL idle_stray_valid got=%h exp=%h", obs, 36'h0); end
    @(posedge clk); #1;
    man_valid = 1'b0;
    @(negedge clk);
    total++;
    if (obs !== 36'h0) begin bad++; $display("FAIL idle_after_stray got=%h exp=%h", obs, 36'h0); end
  endtask

  task automatic test_top_block();
    logic [35:0] exp;
    push_idx = 0;
    for (int c = 0; c <= 14; c++) begin
      @(posedge clk); #1;
      miss = (c == 0); miss_addr = 16'hFFFA;
      @(negedge clk);
      exp = model(c, 16'hFFF0, 0);
      total++;
      if (obs !== exp) begin bad++; $display("FAIL top_block c=%0d got=%h exp=%h", c, obs, exp); end
    end
  endtask

  task automatic test_reset_mid();
    logic [35:0] exp;
    int waited;
    push_idx = 0;
    for (int c = 0; c <= 13; c++) begin
      @(posedge clk); #1;
      miss = (c == 0); miss_addr = 16'h3338; rst = (c == 6);
      @(negedge clk);
      exp = (c <= 6) ? model(c, 16'h3330, 0) : 36'h0;
      total++;
      if (obs !== exp) begin bad++; $display("FAIL reset_mid c=%0d got=%h exp=%h", c, obs, exp); end
    end
    waited = 0;
    while (rq.size() != 0 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    total++;
    if (rq.size() != 0) begin
      bad++; $display("FAIL reset_mid_drain pending=%0d exp=0", rq.size());
      rq.delete();
    end
    push_idx = 0;
    for (int c = 0; c <= 14; c++) begin
      @(posedge clk); #1;
      miss = (c == 0); miss_addr = 16'h0020;
      @(negedge clk);
      exp = model(c, 16'h0020, 0);
      total++;
      if (obs !== exp) begin bad++; $display("FAIL refill c=%0d got=%h exp=%h", c, obs, exp); end
    end
  endtask

  task automatic test_back_to_back();
    logic [35:0] exp;
    push_idx = 0;
    for (int c = 0; c <= 27; c++) begin
      @(posedge clk); #1;
      miss      = (c == 0) || (c == 13);
      miss_addr = (c < 13) ? 16'h0104 : 16'h020C;
      @(negedge clk);
      exp = (c < 13) ? model(c, 16'h0100, 0) : model(c - 13, 16'h0200, 0);
      total++;
      if (obs !== exp) begin bad++; $display("FAIL back_to_back c=%0d got=%h exp=%h", c, obs, exp); end
    end
  endtask

  initial begin
    rst = 1'b1; miss = 1'b0; miss_addr = 16'h0000; man_valid = 1'b0;
    test_reset();
    test_basic();
    test_gapped();
    test_ignored();
    test_top_block();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
